dnn_core_array: RTL and testbench
=================================

# dnn_core_array

Parametrised array of `F_NUM` fixed-point multiply-accumulate lanes, each with its own weight RAM and bias register. It sits between the source buffer / execution controller (which supply `exec`, `ra`, `d`) and the destination buffer. It replaces the fixed 16-lane, real-valued core chain with a width-generic array. New behaviour over the fixed chain:
- rounding and saturation to the output width,
- optional ReLU,
- a valid/ready result stream with backpressure.

## Interface
Parameters:
- `F_NUM`, 16: number of lanes (≥2)
- `DW`, 16: data, weight and bias width (signed, two's complement)
- `FRAC`, 8: fractional bits of the Q format (1 ≤ `FRAC` < `DW`)
- `AW`, 40: accumulator width (≥ 2·`DW`)
- `WA_W`, 10: weight address width (depth 2^`WA_W` per lane)

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `relu`  in  1  clamp negative results to 0; sampled in BIAS
- `enbias`  in  1  add the lane bias; sampled in BIAS
- `w_valid`  in  1  weight/bias write request
- `w_ready`  out  1  write accepted (high only in IDLE)
- `w_lane`  in  $clog2(F_NUM)  target lane
- `w_bias`  in  1  1 = write the bias register, 0 = write the weight RAM
- `w_addr`  in  WA_W  weight RAM address
- `w_data`  in  DW  weight or bias value
- `k_init`  in  1  start kernel: clear accumulators
- `exec`  in  1  MAC strobe
- `ra`  in  WA_W  weight read address (common to all lanes)
- `d`  in  DW  input sample (broadcast to all lanes)
- `k_fin`  in  1  end kernel: finalise and stream results
- `busy`  out  1  state ≠ IDLE
- `o_valid`  out  1  result valid
- `o_data`  out  DW  result, lane 0 first
- `o_last`  out  1  high on the lane `F_NUM`-1 beat
- `o_ready`  in  1  downstream accept

## Operation
- FSM states: IDLE → ACC → DRAIN → BIAS → OUT → IDLE.
- IDLE:
  - A write occurs on `w_valid & w_ready`. Out-of-range `w_lane` writes are dropped.
  - `k_init` → ACC and clears all accumulators. `k_fin` alone is ignored.
- ACC:
  - `exec` samples `ra` and `d`. Pipeline is stage 1: synchronous RAM read plus `d` register; stage 2: signed product (2·DW) sign-extended and added into the AW accumulator (wrap-around, no saturation).
  - `k_init` in ACC re-clears the accumulators and kills in-flight stages.
  - `k_fin` → DRAIN. An `exec` in the same cycle as `k_fin` is accepted.
- DRAIN: exactly 2 cycles; the pipeline empties. `exec` is ignored.
- BIAS: 1 cycle. Each lane computes its result:
  - If `enbias`, add the bias, sign-extended and shifted left by `FRAC`.
  - Round half-up: add 2^(FRAC-1), then arithmetic shift right by `FRAC`.
  - Saturate to [−2^(DW-1), 2^(DW-1)−1].
  - If `relu`, replace negatives with 0.
  - Load the results into the output shift chain.
- OUT:
  - `o_data` is the head of the chain.
  - Each `o_valid & o_ready` shifts the chain toward lane 0.
  - After exactly `F_NUM` beats → IDLE.
  - `k_init`, `k_fin`, `exec` and `w_valid` are ignored.
- Accumulators hold their value after OUT until the next `k_init`.
- Reset (asserted at any time, including mid-OUT):
  - state IDLE; accumulators, bias registers, pipeline and chain cleared;
  - `o_valid`, `o_last`, `o_data` = 0; `busy` = 0; `w_ready` = 1 after release;
  - RAM contents are not reset.

## Timing
- `k_fin` sampled at edge t: DRAIN at t+1 and t+2, BIAS at t+3, `o_valid` high from t+4.
- `exec` at t affects the accumulator at t+2.
- Output handshake:
  - `o_valid` is registered.
  - `o_data`/`o_last` stay stable while `o_valid & ~o_ready`.
  - `o_valid` does not drop until the final beat.
  - Minimum 1 beat per cycle with `o_ready` held high.
- `w_ready` and `busy` are combinational from state. `w_ready` = 0 from the edge the FSM leaves IDLE.

## Structure
- Package `dnn_pkg`:
  - state enum;
  - function `dnn_round_sat(acc, relu)` parametrised on DW, FRAC, AW.
- Sub-module `dnn_mac_lane`:
  - weight RAM, bias register, 2-stage MAC, accumulator, BIAS computation.
- Top: FSM, DRAIN counter, beat counter, output shift chain, write decode across `F_NUM` generate instances.

## Test plan
Defaults; 1.0 = 256.
- Reset mid-OUT after 3 beats → `o_valid` = 0, `busy` = 0, `w_ready` = 1 next cycle; a fresh kernel streams a full 16 beats.
- Lane 0 weights addr0 = 256, addr1 = 512; `k_init`; exec (ra0, d = 768), (ra1, d = 256); `k_fin` with `o_ready` = 1 → beat 0 = 1280 at t+4, beats 1–15 = 0, `o_last` on beat 15 only.
- Lane 1 bias = −2560, acc = 1280, `enbias` = 1 → `relu` = 0 gives −1280, `relu` = 1 gives 0; `enbias` = 0 gives 1280.
- Weight 32767, d = 32767, 4 execs → 32767; weight −32768, d = 32767 → −32768; acc = 384 (1.5 after shift, rounding half-up) with d = 1 → 2.
- `o_ready` pattern 1,0,1,0… → exactly 16 beats, `o_data` stable across stalls, no duplicate or dropped lane.
- `k_init` mid-ACC after 2 execs, then 1 exec (256 × 256), `k_fin` → 256. `w_valid` during OUT → `w_ready` = 0 and the RAM is unchanged.

Source files
------------

// File: rtl/dnn_pkg.sv
// dnn_pkg: FSM state type and the round/saturate/ReLU helper shared by the MAC array.
package dnn_pkg;

    typedef enum logic [2:0] {IDLE, ACC, DRAIN, BIAS, OUT} state_t;

    localparam int MAXW = 128;

    // Callers sign-extend their AW-wide accumulator to MAXW so the rounding add never wraps.
    function automatic logic signed [MAXW-1:0] dnn_round_sat(
        input logic signed [MAXW-1:0] acc,
        input logic                   relu,
        input int                     dw,
        input int                     frac
    );
        logic signed [MAXW-1:0] r, hi, lo;
        r  = acc + (MAXW'(1) << (frac - 1));
        r  = r >>> frac;
        hi = (MAXW'(1) << (dw - 1)) - 1'b1;
        lo = ~hi;
        r  = r > hi ? hi : r < lo ? lo : r;
        return (relu && r < 0) ? '0 : r;
    endfunction

endpackage

// File: rtl/dnn_if.sv
// dnn_if: weight/bias write port, kernel control, MAC input and result stream of the MAC array.
interface dnn_if #(
    parameter int F_NUM = 16,
    parameter int DW    = 16,
    parameter int WA_W  = 10
);
    localparam int LW = $clog2(F_NUM);

    logic            relu, enbias;
    logic            w_valid, w_ready, w_bias;
    logic [LW-1:0]   w_lane;
    logic [WA_W-1:0] w_addr, ra;
    logic [DW-1:0]   w_data, d, o_data;
    logic            k_init, exec, k_fin, busy;
    logic            o_valid, o_last, o_ready;

    modport master (
        output relu, enbias, w_valid, w_lane, w_bias, w_addr, w_data,
               k_init, exec, ra, d, k_fin, o_ready,
        input  w_ready, busy, o_valid, o_data, o_last
    );

    modport slave (
        input  relu, enbias, w_valid, w_lane, w_bias, w_addr, w_data,
               k_init, exec, ra, d, k_fin, o_ready,
        output w_ready, busy, o_valid, o_data, o_last
    );

endinterface

// File: rtl/dnn_core_array_lane.sv
// dnn_mac_lane: one lane with weight RAM, bias register, 2-stage MAC and result rounding.
module dnn_mac_lane
    import dnn_pkg::*;
#(
    parameter int DW   = 16,
    parameter int FRAC = 8,
    parameter int AW   = 40,
    parameter int WA_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_w,
    input  logic            we_b,
    input  logic [WA_W-1:0] w_addr,
    input  logic [DW-1:0]   w_data,
    input  logic            clr,
    input  logic            exec,
    input  logic [WA_W-1:0] ra,
    input  logic [DW-1:0]   d,
    input  logic            enbias,
    input  logic            relu,
    output logic [DW-1:0]   result
);

    logic signed [DW-1:0]   mem [2**WA_W];
    logic signed [DW-1:0]   rd, d1, bias;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc, sum;
    logic                   v1;

    // RAM contents survive reset; rd is qualified by v1, so it needs no reset either.
    always_ff @(posedge clk) begin
        if (we_w) mem[w_addr] <= w_data;
        if (exec) rd <= mem[ra];
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v1   <= 1'b0;
            d1   <= '0;
            bias <= '0;
            acc  <= '0;
        end else begin
            v1 <= exec;
            if (exec) d1 <= d;
            if (we_b) bias <= w_data;
            if (clr) acc <= '0;
            else if (v1) acc <= acc + AW'(prod);
        end

    assign prod   = rd * d1;
    assign sum    = acc + (enbias ? (AW'(bias) <<< FRAC) : '0);
    assign result = DW'(dnn_round_sat(MAXW'(sum), relu, DW, FRAC));

endmodule

// File: rtl/dnn_core_array.sv
// dnn_core_array: F_NUM-lane fixed-point MAC array streaming rounded, saturated results lane 0 first.
module dnn_core_array
    import dnn_pkg::*;
#(
    parameter int F_NUM = 16,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int AW    = 40,
    parameter int WA_W  = 10
) (
    input logic clk,
    input logic rst_n,
    dnn_if.slave bus
);

    localparam int CW = $clog2(F_NUM);

    state_t                   state;
    logic                     dcnt, vld, lst, wr, clr, ex;
    logic [CW-1:0]            beat;
    logic [F_NUM-1:0][DW-1:0] chain, res;

    assign bus.w_ready = state == IDLE;
    assign bus.busy    = state != IDLE;
    assign bus.o_valid = vld;
    assign bus.o_last  = lst;
    assign bus.o_data  = chain[0];

    assign wr  = bus.w_valid && state == IDLE;
    assign clr = bus.k_init && (state == IDLE || state == ACC);
    // A k_init in ACC wins over a coincident exec so the fresh kernel starts empty.
    assign ex  = bus.exec && !bus.k_init && state == ACC;

    for (genvar i = 0; i < F_NUM; i++) begin : g_lane
        dnn_mac_lane #(.DW(DW), .FRAC(FRAC), .AW(AW), .WA_W(WA_W)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .we_w   (wr && !bus.w_bias && bus.w_lane == CW'(i)),
            .we_b   (wr && bus.w_bias && bus.w_lane == CW'(i)),
            .w_addr (bus.w_addr),
            .w_data (bus.w_data),
            .clr    (clr),
            .exec   (ex),
            .ra     (bus.ra),
            .d      (bus.d),
            .enbias (bus.enbias),
            .relu   (bus.relu),
            .result (res[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            dcnt  <= 1'b0;
            beat  <= '0;
            chain <= '0;
            vld   <= 1'b0;
            lst   <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (bus.k_init) state <= ACC;
                ACC:   if (bus.k_fin && !bus.k_init) begin
                    state <= DRAIN;
                    dcnt  <= 1'b0;
                end
                DRAIN: begin
                    dcnt <= 1'b1;
                    if (dcnt) state <= BIAS;
                end
                BIAS:  begin
                    state <= OUT;
                    chain <= res;
                    vld   <= 1'b1;
                    lst   <= 1'b0;
                    beat  <= '0;
                end
                OUT:   if (bus.o_ready) begin
                    chain <= {DW'(0), chain[F_NUM-1:1]};
                    beat  <= beat + 1'b1;
                    lst   <= beat == CW'(F_NUM - 2);
                    if (beat == CW'(F_NUM - 1)) begin
                        state <= IDLE;
                        vld   <= 1'b0;
                        lst   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_dnn_core_array.sv
// tb_dnn_core_array: directed checks of the MAC array with hand-computed Q8.8 results.
module tb_dnn_core_array;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int failed = 0;
    logic [15:0] got [16];
    logic lst [16];
    int nb, unstable, exp_d [16];
    logic tail_valid;

    dnn_if #(.F_NUM(16), .DW(16), .WA_W(10)) bus ();

    dnn_core_array #(.F_NUM(16), .DW(16), .FRAC(8), .AW(40), .WA_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic wr(input int lane, input bit b, input int addr, input int data);
        bus.w_valid = 1'b1;
        bus.w_lane  = 4'(lane);
        bus.w_bias  = b;
        bus.w_addr  = 10'(addr);
        bus.w_data  = 16'(data);
        step;
        bus.w_valid = 1'b0;
    endtask

    task automatic kinit;
        bus.k_init = 1'b1;
        step;
        bus.k_init = 1'b0;
    endtask

    task automatic ex(input int ra, input int dv);
        bus.exec = 1'b1;
        bus.ra   = 10'(ra);
        bus.d    = 16'(dv);
        step;
        bus.exec = 1'b0;
    endtask

    task automatic kfin(input bit en, input bit rl);
        bus.enbias = en;
        bus.relu   = rl;
        bus.k_fin  = 1'b1;
        step;
        bus.k_fin  = 1'b0;
    endtask

    task automatic set_exp(input int l0, input int l1);
        for (int i = 0; i < 16; i++) exp_d[i] = 0;
        exp_d[0] = l0;
        exp_d[1] = l1;
    endtask

    // Records up to maxb beats; alt drives o_ready 1,0,1,0... and counts any stall-cycle change.
    task automatic collect(input bit alt, input int maxb);
        int cyc = 0;
        bit stall = 1'b0;
        logic [15:0] pd = '0;
        logic pl = 1'b0;
        nb = 0;
        unstable = 0;
        while (nb < maxb && cyc < 200) begin
            bus.o_ready = alt ? (cyc % 2 == 0) : 1'b1;
            if (stall && (bus.o_data !== pd || bus.o_last !== pl || bus.o_valid !== 1'b1)) unstable++;
            stall = bus.o_valid && !bus.o_ready;
            pd = bus.o_data;
            pl = bus.o_last;
            if (bus.o_valid && bus.o_ready) begin
                got[nb] = bus.o_data;
                lst[nb] = bus.o_last;
                nb++;
            end
            step;
            cyc++;
        end
        bus.o_ready = 1'b0;
        tail_valid = bus.o_valid;
    endtask

    task automatic test_reset;
        step;
        #1;
        tests++;
        if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 || bus.o_data !== 16'd0 || bus.busy !== 1'b0 || bus.w_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_state: valid %b last %b data %0d busy %b w_ready %b, want 0 0 0 0 1",
                     bus.o_valid, bus.o_last, bus.o_data, bus.busy, bus.w_ready);
        end
        step;
        rst_n = 1'b1;
        step;
        for (int l = 0; l < 16; l++)
            for (int a = 0; a < 8; a++) wr(l, 1'b0, a, 0);
    endtask

    task automatic test_basic;
        wr(0, 1'b0, 0, 256);
        wr(0, 1'b0, 1, 512);
        kinit;
        ex(0, 768);
        ex(1, 256);
        kfin(1'b0, 1'b0);
        tests++;
        if (bus.busy !== 1'b1 || bus.o_valid !== 1'b0 || bus.w_ready !== 1'b0) begin
            failed++;
            $display("FAIL basic_drain: busy %b valid %b w_ready %b, want 1 0 0", bus.busy, bus.o_valid, bus.w_ready);
        end
        step;
        step;
        tests++;
        if (bus.o_valid !== 1'b0) begin
            failed++;
            $display("FAIL basic_t3_valid: got %b want 0", bus.o_valid);
        end
        step;
        tests++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 16'd1280) begin
            failed++;
            $display("FAIL basic_t4: valid %b data %0d, want 1 1280", bus.o_valid, $signed(bus.o_data));
        end
        collect(1'b0, 16);
        set_exp(1280, 0);
        tests++;
        if (nb != 16 || tail_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL basic_beats: beats %0d tail_valid %b busy %b, want 16 0 0", nb, tail_valid, bus.busy);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (got[i] !== 16'(exp_d[i]) || lst[i] !== (i == 15)) begin
                failed++;
                $display("FAIL basic_lane%0d: data %0d last %b, want %0d %b", i, $signed(got[i]), lst[i], exp_d[i], i == 15);
            end
        end
    endtask

    task automatic test_bias;
        bit en [3] = '{1'b1, 1'b1, 1'b0};
        bit rl [3] = '{1'b0, 1'b1, 1'b0};
        int want [3] = '{-1280, 0, 1280};
        wr(1, 1'b1, 0, -2560);
        wr(1, 1'b0, 2, 256);
        for (int c = 0; c < 3; c++) begin
            kinit;
            ex(2, 1280);
            kfin(en[c], rl[c]);
            collect(1'b0, 16);
            set_exp(0, want[c]);
            tests++;
            if (nb != 16) begin
                failed++;
                $display("FAIL bias%0d_beats: got %0d want 16", c, nb);
            end
            for (int i = 0; i < 2; i++) begin
                tests++;
                if (got[i] !== 16'(exp_d[i])) begin
                    failed++;
                    $display("FAIL bias%0d_lane%0d: got %0d want %0d", c, i, $signed(got[i]), exp_d[i]);
                end
            end
        end
        bus.enbias = 1'b0;
        bus.relu   = 1'b0;
    endtask

    task automatic test_saturate;
        int addr [4] = '{3, 4, 5, 6};
        int reps [4] = '{4, 1, 1, 1};
        int dv   [4] = '{32767, 32767, 1, 1};
        int want [4] = '{32767, -32768, 2, -1};
        wr(0, 1'b0, 3, 32767);
        wr(0, 1'b0, 4, -32768);
        wr(0, 1'b0, 5, 384);
        wr(0, 1'b0, 6, -384);
        for (int c = 0; c < 4; c++) begin
            kinit;
            for (int r = 0; r < reps[c]; r++) ex(addr[c], dv[c]);
            kfin(1'b0, 1'b0);
            collect(1'b0, 16);
            tests++;
            if (nb != 16 || got[0] !== 16'(want[c]) || got[1] !== 16'd0) begin
                failed++;
                $display("FAIL sat%0d: beats %0d lane0 %0d lane1 %0d, want 16 %0d 0",
                         c, nb, $signed(got[0]), $signed(got[1]), want[c]);
            end
        end
    endtask

    task automatic test_backpressure;
        for (int l = 0; l < 16; l++) wr(l, 1'b0, 7, (l + 1) * 256);
        kinit;
        ex(7, 256);
        kfin(1'b0, 1'b0);
        collect(1'b1, 16);
        tests++;
        if (nb != 16 || unstable != 0 || tail_valid !== 1'b0) begin
            failed++;
            $display("FAIL bp_stream: beats %0d unstable %0d tail_valid %b, want 16 0 0", nb, unstable, tail_valid);
        end
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (got[i] !== 16'((i + 1) * 256) || lst[i] !== (i == 15)) begin
                failed++;
                $display("FAIL bp_lane%0d: data %0d last %b, want %0d %b", i, $signed(got[i]), lst[i], (i + 1) * 256, i == 15);
            end
        end
    endtask

    task automatic test_kinit_mid;
        kinit;
        ex(0, 768);
        ex(1, 256);
        kinit;
        ex(0, 256);
        kfin(1'b0, 1'b0);
        collect(1'b0, 16);
        tests++;
        if (nb != 16 || got[0] !== 16'd256 || got[1] !== 16'd0) begin
            failed++;
            $display("FAIL kinit_mid: beats %0d lane0 %0d lane1 %0d, want 16 256 0", nb, $signed(got[0]), $signed(got[1]));
        end
    endtask

    task automatic test_write_during_out;
        kinit;
        ex(0, 256);
        kfin(1'b0, 1'b0);
        step;
        step;
        step;
        bus.w_valid = 1'b1;
        bus.w_lane  = 4'd0;
        bus.w_bias  = 1'b0;
        bus.w_addr  = 10'd0;
        bus.w_data  = 16'd999;
        #1;
        tests++;
        if (bus.w_ready !== 1'b0 || bus.busy !== 1'b1 || bus.o_valid !== 1'b1) begin
            failed++;
            $display("FAIL out_w_ready: w_ready %b busy %b valid %b, want 0 1 1", bus.w_ready, bus.busy, bus.o_valid);
        end
        step;
        bus.w_valid = 1'b0;
        collect(1'b0, 16);
        kinit;
        ex(0, 256);
        kfin(1'b0, 1'b0);
        collect(1'b0, 16);
        tests++;
        if (nb != 16 || got[0] !== 16'd256) begin
            failed++;
            $display("FAIL out_ram_kept: beats %0d lane0 %0d, want 16 256", nb, $signed(got[0]));
        end
    endtask

    task automatic test_reset_mid_out;
        kinit;
        ex(0, 256);
        kfin(1'b0, 1'b0);
        collect(1'b0, 3);
        tests++;
        if (nb != 3 || got[0] !== 16'd256 || bus.o_valid !== 1'b1) begin
            failed++;
            $display("FAIL rst_pre: beats %0d lane0 %0d valid %b, want 3 256 1", nb, $signed(got[0]), bus.o_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.o_valid !== 1'b0 || bus.busy !== 1'b0 || bus.o_data !== 16'd0 || bus.o_last !== 1'b0) begin
            failed++;
            $display("FAIL rst_async: valid %b busy %b data %0d last %b, want 0 0 0 0",
                     bus.o_valid, bus.busy, bus.o_data, bus.o_last);
        end
        step;
        rst_n = 1'b1;
        step;
        tests++;
        if (bus.w_ready !== 1'b1 || bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL rst_release: w_ready %b busy %b, want 1 0", bus.w_ready, bus.busy);
        end
        kfin(1'b0, 1'b0);
        tests++;
        if (bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL idle_kfin: busy %b want 0", bus.busy);
        end
        kinit;
        ex(0, 256);
        kfin(1'b0, 1'b0);
        collect(1'b0, 16);
        tests++;
        if (nb != 16 || got[0] !== 16'd256 || lst[15] !== 1'b1 || tail_valid !== 1'b0) begin
            failed++;
            $display("FAIL rst_fresh: beats %0d lane0 %0d last15 %b tail_valid %b, want 16 256 1 0",
                     nb, $signed(got[0]), lst[15], tail_valid);
        end
    endtask

    initial begin
        bus.relu    = 1'b0;
        bus.enbias  = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_lane  = '0;
        bus.w_bias  = 1'b0;
        bus.w_addr  = '0;
        bus.w_data  = '0;
        bus.k_init  = 1'b0;
        bus.exec    = 1'b0;
        bus.ra      = '0;
        bus.d       = '0;
        bus.k_fin   = 1'b0;
        bus.o_ready = 1'b0;
        test_reset;
        test_basic;
        test_bias;
        test_saturate;
        test_backpressure;
        test_kinit_mid;
        test_write_during_out;
        test_reset_mid_out;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
